pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, flush, and bubble clearing of control fields. It is the successor to the fixed-field ID/RR stage register and is placed between any two pipeline stages (IF/ID, ID/RR, RR/EX, EX/MEM, MEM/WB). Each instance carries an opaque payload plus a control vector that is forced to zero whenever the stage outputs a bubble. Upstream `in_ready` depends only on registered state, so back-pressure is never a combinational path.

## Interface
- `DATA_W`, 64: payload width (PC, IW, immediate, destination register, ...); held through bubbles.
- `CTRL_W`, 8: control width (jump, stop, write-mem, write-reg, ...); zeroed on bubble.
- `CNT_W`, 16: width of each performance counter; only used with `PIPE_STAGE_CNT_EN`.
- `clk`  in  1  stage clock; all state updates on the falling edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; equals `state != TWO`.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control vector.
- `flush`  in  1  squash all held and incoming entries (branch/jump resolution).
- `out_valid`  out  1  `out_data`/`out_ctrl` are valid.
- `out_ready`  in  1  downstream accepts (de-asserted on stall).
- `out_data`  out  DATA_W  registered payload.
- `out_ctrl`  out  CTRL_W  registered control; 0 whenever `out_valid` = 0.
- `stall_cnt`  out  CNT_W  edges with `out_valid` & !`out_ready` (macro only).
- `bubble_cnt`  out  CNT_W  edges with !`out_valid` (macro only).

## Operation
- Input transfer (`in_x`) = `in_valid` & `in_ready`. Output transfer (`out_x`) = `out_valid` & `out_ready`.
- States:
  - EMPTY: output register empty.
  - ONE: output register holds an entry.
  - TWO: output register and skid buffer both hold entries.
- Transitions from EMPTY:
  - `in_x` → ONE; output register loads the input.
- Transitions from ONE:
  - `in_x` & `out_x` → ONE; output register loads the input.
  - `in_x` only → TWO; skid loads the input.
  - `out_x` only → EMPTY.
  - neither → hold.
- Transitions from TWO:
  - `out_x` → ONE; output register loads from skid.
  - no `out_x` → hold. `in_x` is impossible in TWO.
- `out_valid` = (`state != EMPTY`).
- On entry to EMPTY, `out_ctrl` is cleared to 0 and `out_data` is left unchanged.
- Flush:
  - Priority is reset > flush > normal.
  - Next state is EMPTY, `out_ctrl` = 0, skid is invalidated, and `out_data` is held.
  - An input presented on the same edge is dropped, even though `in_ready` was 1.
- Reset values:
  - state EMPTY, so `in_ready` = 1 and `out_valid` = 0.
  - `out_data` = 0, `out_ctrl` = 0, skid contents = 0, counters = 0.
- Reset mid-operation: all in-flight entries are discarded on the first falling edge with `resetn` = 0.
- Handshake rules the stage relies on:
  - Upstream must not change `in_data`/`in_ctrl` while `in_valid` & !`in_ready`.
  - Downstream may de-assert `out_ready` at any time.

## Timing
- Latency is one falling edge from `in_x` to `out_valid`, in EMPTY, or in ONE with `out_x`.
- Throughput is one entry per cycle with `out_ready` held high.
- After a single-cycle stall, full rate resumes with no bubble, because the skid absorbs the extra entry.
- `in_ready` is a function of state only, so there is no `out_ready`→`in_ready` combinational path.
- `out_*` are driven straight from registers.
- Flush takes effect on the same edge, and `out_valid` = 0 after that edge.

## Configuration
- `PIPE_STAGE_CNT_EN` defined:
  - `stall_cnt` and `bubble_cnt` are present.
  - Both saturate at 2^CNT_W−1 and are cleared only by reset.
  - Flush cycles count as bubbles on the following edges.
- `PIPE_STAGE_CNT_EN` undefined:
  - Both ports are tied to 0 and the counter logic is absent.
  - Handshake behaviour is identical in both builds.

## Structure
- Package `pipe_pkg` holds:
  - state enum (EMPTY, ONE, TWO).
  - `CTRL` bit-position constants (JUMP[1:0], STOP, W_MEM, W_REG, ...) shared by all stage instances.
- One sub-module: `sat_counter` (parameter `CNT_W`; inputs `inc`, `clk`, `resetn`; output `cnt`). It is instantiated twice, and only under the macro.

## Test plan
- Reset behaviour: hold `resetn` = 0 for 2 edges with `in_valid` = 1 and data 0xAB → `out_valid` = 0, `out_data` = 0, `out_ctrl` = 0, `in_ready` = 1.
- Streaming: send 8 back-to-back entries (data 1..8, ctrl 0x0F) with `out_ready` = 1 → outputs 1..8 on consecutive edges, 1 edge of latency, `in_ready` always 1.
- Stall and skid: while data 5 is in the output register and data 6 is arriving, de-assert `out_ready` for 3 edges → state TWO, `in_ready` = 0, `out_data` holds 5; on release, 5, 6 and 7 appear on consecutive edges with no loss or duplication.
- Flush in TWO: state TWO with 0x11/0x12 held and `in_valid` = 1 with 0x13, assert `flush` → `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0x11; 0x12 and 0x13 never appear.
- Bubble clearing: `in_valid` = 0 after entry ctrl 0xFF is consumed → `out_ctrl` = 0x00 and `out_data` retains its last value.
- Counters (macro on, `CNT_W` = 2): 5 stalled edges → `stall_cnt` = 3 (saturated); reset → 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg
// ----------------------------------------------------------------------------
// Shared definitions for every pipe_stage_buf instance in the pipeline
// (IF/ID, ID/RR, RR/EX, EX/MEM, MEM/WB).
//
// Contents:
//   stage_state_t  - occupancy of a stage (EMPTY / ONE / TWO)
//   CTRL_*         - bit positions inside the control vector, so every
//                    stage agrees on where jump/stop/write-enable bits live
//   stage_accepts  - whether a stage in a given state can take a new entry
// ============================================================================
package pipe_pkg;

    // EMPTY: nothing held, ONE: output register full, TWO: output + skid full
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Control vector layout shared by all stage instances
    localparam int CTRL_JUMP_LO = 0;
    localparam int CTRL_JUMP_HI = 1;
    localparam int CTRL_STOP    = 2;
    localparam int CTRL_W_MEM   = 3;
    localparam int CTRL_W_REG   = 4;
    localparam int CTRL_R_MEM   = 5;

    // A stage can accept exactly when its skid buffer is free. Keeping this
    // a pure function of state guarantees there is never a combinational
    // path from downstream ready to upstream ready.
    function automatic logic stage_accepts(input stage_state_t s);
        return (s != TWO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
// ----------------------------------------------------------------------------
// Saturating up-counter used for pipeline performance statistics. Counts
// once per falling clock edge while 'inc' is high and sticks at its maximum
// value. Cleared only by reset.
//
// Ports:
//   clk     in   clock, updates on the falling edge
//   resetn  in   synchronous active-low reset
//   inc     in   count enable for this edge
//   cnt     out  [CNT_W-1:0] current count
// ============================================================================
module sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count up while enabled, stopping at all-ones instead of wrapping
    always_ff @(negedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_STEP;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf
// ----------------------------------------------------------------------------
// Generic pipeline stage register with valid/ready handshake and a one-entry
// skid buffer. The payload (out_data) is opaque and held through bubbles;
// the control vector (out_ctrl) is forced to zero whenever the stage holds
// no valid entry, so a bubble can never trigger a write or a jump.
// All state updates happen on the falling edge of clk.
//
// Optional feature: define PIPE_STAGE_CNT_EN to build the stall and bubble
// performance counters; otherwise those ports are tied to zero.
//
// Ports:
//   clk         in   stage clock (falling edge active)
//   resetn      in   synchronous active-low reset
//   in_valid    in   upstream offers an entry
//   in_ready    out  stage can accept (depends on state only)
//   in_data     in   [DATA_W-1:0] upstream payload
//   in_ctrl     in   [CTRL_W-1:0] upstream control vector
//   flush       in   squash held and incoming entries
//   out_valid   out  out_data/out_ctrl hold a valid entry
//   out_ready   in   downstream accepts
//   out_data    out  [DATA_W-1:0] registered payload
//   out_ctrl    out  [CTRL_W-1:0] registered control, 0 on bubble
//   stall_cnt   out  [CNT_W-1:0] edges with out_valid & !out_ready
//   bubble_cnt  out  [CNT_W-1:0] edges with !out_valid
// ============================================================================
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    stage_state_t      state_q;
    stage_state_t      state_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_x;
    logic              out_x;

    assign in_x  = in_valid & in_ready;
    assign out_x = out_valid & out_ready;

    // State register
    always_ff @(negedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every handshake outcome
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_x) state_d = ONE;
                end
                ONE: begin
                    if (in_x && !out_x)      state_d = TWO;
                    else if (!in_x && out_x) state_d = EMPTY;
                end
                TWO: begin
                    if (out_x) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake outputs, derived from registered state only
    always_comb begin
        in_ready  = stage_accepts(state_q);
        out_valid = (state_q != EMPTY);
    end

    // Datapath: output register and skid buffer. Whenever the stage drops
    // to EMPTY the control vector is cleared while the payload is kept, so
    // downstream sees a harmless bubble that still shows the last PC/IW.
    always_ff @(negedge clk) begin
        if (!resetn) begin
            out_data    <= '0;
            out_ctrl    <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush) begin
            out_ctrl <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_x) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end
                end
                ONE: begin
                    if (in_x && out_x) begin
                        out_data <= in_data;
                        out_ctrl <= in_ctrl;
                    end else if (in_x) begin
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                    end else if (out_x) begin
                        out_ctrl <= '0;
                    end
                end
                TWO: begin
                    if (out_x) begin
                        out_data <= skid_data_q;
                        out_ctrl <= skid_ctrl_q;
                    end
                end
                default: begin
                    out_ctrl <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_CNT_EN
    // Performance counters sample the handshake seen on each edge; a flush
    // shows up as bubbles on the edges that follow it.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (out_valid & ~out_ready),
        .cnt    (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (~out_valid),
        .cnt    (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ============================================================================
// tb_pipe_stage_buf
// ----------------------------------------------------------------------------
// Directed bench for pipe_stage_buf. Inputs change on the rising edge and
// outputs are checked 1 time unit after the falling (active) edge. Expected
// values are written out by hand for each step.
// ============================================================================
module tb_pipe_stage_buf;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 2;

`ifdef PIPE_STAGE_CNT_EN
    localparam logic CNT_ON = 1'b1;
`else
    localparam logic CNT_ON = 1'b0;
`endif

    logic              clk;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    int checks_total;
    int checks_pass;
    int checks_fail;

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one set of inputs at the rising edge, then let one falling
    // edge happen and settle before returning.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                                 input logic [CTRL_W-1:0] c, input logic ordy,
                                 input logic fl);
        @(posedge clk);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        checks_total++;
        assert (obs === exp) checks_pass++;
        else begin
            checks_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_valid,
                               input logic exp_ready,
                               input logic [DATA_W-1:0] exp_data,
                               input logic [CTRL_W-1:0] exp_ctrl);
        checkVal({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
        checkVal({tag, ".in_ready"},  {63'd0, in_ready},  {63'd0, exp_ready});
        checkVal({tag, ".out_data"},  out_data, exp_data);
        checkVal({tag, ".out_ctrl"},  {56'd0, out_ctrl}, {56'd0, exp_ctrl});
    endtask

    task automatic checkCounters(input string tag, input logic [CNT_W-1:0] exp_stall,
                                 input logic [CNT_W-1:0] exp_bubble);
        checkVal({tag, ".stall_cnt"},  {62'd0, stall_cnt},  {62'd0, exp_stall});
        checkVal({tag, ".bubble_cnt"}, {62'd0, bubble_cnt}, {62'd0, exp_bubble});
    endtask

    initial begin
        checks_total = 0;
        checks_pass  = 0;
        checks_fail  = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b1;
        flush     = 1'b0;

        // Reset with a valid input offered: nothing may be captured
        $display("[TB] reset");
        applyStimulus(1'b1, 64'hAB, 8'h0F, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'hAB, 8'h0F, 1'b1, 1'b0);
        checkOutput("reset", 1'b0, 1'b1, 64'h0, 8'h00);
        checkCounters("reset", 2'd0, 2'd0);
        resetn = 1'b1;

        // Back-to-back streaming, one edge of latency
        $display("[TB] streaming");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 64'(k), 8'h0F, 1'b1, 1'b0);
            checkOutput($sformatf("stream%0d", k), 1'b1, 1'b1, 64'(k), 8'h0F);
        end
        applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        checkOutput("stream_drain", 1'b0, 1'b1, 64'd8, 8'h00);

        // Stall with skid: 5 in output register, 6 arriving, ready low 3 edges
        $display("[TB] stall and skid");
        applyStimulus(1'b1, 64'd4, 8'h44, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'd5, 8'h45, 1'b1, 1'b0);
        checkOutput("skid_pre", 1'b1, 1'b1, 64'd5, 8'h45);
        applyStimulus(1'b1, 64'd6, 8'h46, 1'b0, 1'b0);
        checkOutput("skid_stall1", 1'b1, 1'b0, 64'd5, 8'h45);
        applyStimulus(1'b1, 64'd7, 8'h47, 1'b0, 1'b0);
        checkOutput("skid_stall2", 1'b1, 1'b0, 64'd5, 8'h45);
        applyStimulus(1'b1, 64'd7, 8'h47, 1'b0, 1'b0);
        checkOutput("skid_stall3", 1'b1, 1'b0, 64'd5, 8'h45);
        applyStimulus(1'b1, 64'd7, 8'h47, 1'b1, 1'b0);
        checkOutput("skid_rel6", 1'b1, 1'b1, 64'd6, 8'h46);
        applyStimulus(1'b1, 64'd7, 8'h47, 1'b1, 1'b0);
        checkOutput("skid_rel7", 1'b1, 1'b1, 64'd7, 8'h47);
        applyStimulus(1'b1, 64'd8, 8'h48, 1'b1, 1'b0);
        checkOutput("skid_rel8", 1'b1, 1'b1, 64'd8, 8'h48);
        applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        checkOutput("skid_drain", 1'b0, 1'b1, 64'd8, 8'h00);

        // Flush while in TWO with a third entry offered
        $display("[TB] flush in TWO");
        applyStimulus(1'b1, 64'h11, 8'h21, 1'b0, 1'b0);
        checkOutput("flush_one", 1'b1, 1'b1, 64'h11, 8'h21);
        applyStimulus(1'b1, 64'h12, 8'h22, 1'b0, 1'b0);
        checkOutput("flush_two", 1'b1, 1'b0, 64'h11, 8'h21);
        applyStimulus(1'b1, 64'h13, 8'h23, 1'b0, 1'b1);
        checkOutput("flush_edge", 1'b0, 1'b1, 64'h11, 8'h00);
        applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_after", 1'b0, 1'b1, 64'h11, 8'h00);
        applyStimulus(1'b1, 64'h14, 8'h24, 1'b1, 1'b0);
        checkOutput("flush_next", 1'b1, 1'b1, 64'h14, 8'h24);

        // Flush drops an input even though in_ready is high
        applyStimulus(1'b1, 64'h15, 8'h25, 1'b1, 1'b1);
        checkOutput("flush_drop", 1'b0, 1'b1, 64'h14, 8'h00);

        // Bubble clearing after a full-control entry is consumed
        $display("[TB] bubble clearing");
        applyStimulus(1'b1, 64'h33, 8'hFF, 1'b1, 1'b0);
        checkOutput("bubble_load", 1'b1, 1'b1, 64'h33, 8'hFF);
        applyStimulus(1'b0, 64'h99, 8'hAA, 1'b1, 1'b0);
        checkOutput("bubble_clear", 1'b0, 1'b1, 64'h33, 8'h00);

        // Counters: reset, one bubble edge, then five stalled edges
        $display("[TB] counters");
        resetn = 1'b0;
        applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
        checkCounters("cnt_reset", 2'd0, 2'd0);
        resetn = 1'b1;
        applyStimulus(1'b1, 64'h50, 8'h01, 1'b0, 1'b0);
        checkOutput("cnt_load", 1'b1, 1'b1, 64'h50, 8'h01);
        checkCounters("cnt_bubble", 2'd0, CNT_ON ? 2'd1 : 2'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        end
        checkCounters("cnt_sat", CNT_ON ? 2'd3 : 2'd0, CNT_ON ? 2'd1 : 2'd0);

        // Reset mid-operation discards the held entry and clears counters
        resetn = 1'b0;
        applyStimulus(1'b1, 64'h60, 8'h02, 1'b0, 1'b0);
        checkOutput("mid_reset", 1'b0, 1'b1, 64'h0, 8'h00);
        checkCounters("mid_reset", 2'd0, 2'd0);
        resetn = 1'b1;

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
